mpu_cmd_ctrl: RTL and testbench
===============================

Name: mpu_cmd_ctrl

Overview:
Parametrised successor to the single-byte MPU command FSM. It assembles multi-byte operands from the UART receive stream and drives an external combinational or pipelined ALU. It then serialises the DATA_W-bit result back to the UART transmitter under a busy handshake. New over the previous generation: configurable operand width and ALU latency, result chaining, inter-byte timeout, and error reporting.

Parameters:
DATA_W, 16, operand/result width; multiple of 8, range 8..32; NB = DATA_W/8 bytes per operand
FUNC_W, 4, ALU function code width; must be <= 7
ALU_LAT, 1, cycles from stable alu_a/alu_b/alu_func to valid alu_result; >= 1
TIMEOUT, 50000, max clk cycles between received bytes inside a frame
ERR_BYTE, 8'hEE, byte transmitted on frame abort

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
rx_data  input  8  received byte, valid with rx_complete
rx_complete  input  1  one-cycle pulse: rx_data valid
rx_error  input  1  one-cycle pulse: framing/parity error on current byte
alu_result  input  DATA_W  ALU output
alu_a  output  DATA_W  operand A register
alu_b  output  DATA_W  operand B register
alu_func  output  FUNC_W  function register
txd  output  8  byte to transmit, held stable while tx_en high
tx_en  output  1  one-cycle transmit strobe
tx_busy  input  1  transmitter busy; no tx_en while high
busy  output  1  high in any state other than IDLE
err_flag  output  1  sticky abort indicator

Behaviour:
- Reset (rst sampled high): state=IDLE; alu_a, alu_b, alu_func, txd, result register, byte counter, timeout counter = 0; tx_en=0; busy=0; err_flag=0. Reset takes effect from any state, including mid-TX; a pending tx_en is not issued.
- Frame format: opcode byte, then NB bytes of A, then NB bytes of B. Operand bytes are LSB first. Opcode[FUNC_W-1:0] = func; opcode[7] = CHAIN; remaining bits are ignored.
- IDLE: on rx_complete (without rx_error), load alu_func and latch CHAIN, clear err_flag, go to RX_A with byte count 0.
- RX_A: each rx_complete writes rx_data into byte[count] of alu_a. After byte NB-1: if CHAIN, alu_b <= result register and go to EXEC; else go to RX_B.
- RX_B: same fill for alu_b; after byte NB-1 go to EXEC.
- Operand registers update in the same cycle as the accepting rx_complete; no partial-shift artefacts are visible.
- EXEC: hold for exactly ALU_LAT cycles, then capture alu_result into the result register; go to TX with byte index 0.
- TX: when tx_busy=0 and no strobe was issued in the previous cycle, drive txd = result byte[index] (LSB first) and pulse tx_en for 1 cycle; increment index. After byte NB-1 is strobed, go to IDLE.
- The minimum gap between strobes is 1 cycle, so the transmitter has time to raise tx_busy.
- ERR: send ERR_BYTE once, using the same strobe rule as TX; set err_flag; return to IDLE. The result register is unchanged.
- Timeout: the counter clears on every rx_complete and on state entry, and counts in RX_A/RX_B. Reaching TIMEOUT -> ERR.
- rx_error in RX_A/RX_B -> ERR. rx_error in IDLE -> set err_flag only, stay in IDLE, no transmit. If rx_complete and rx_error arrive in the same cycle, the error wins and the byte is discarded.
- rx_complete in EXEC/TX/ERR is dropped silently; it is not queued.
- Result register persists across frames; it is 0 after reset, so CHAIN with no prior result uses B=0.
- Latency: the last operand byte's rx_complete at cycle t -> result captured at t+1+ALU_LAT. With tx_busy=0, the first tx_en occurs at the next cycle.

Test Plan:
- DATA_W=16, ALU=add, func 0x1: bytes 01,34,12,01,00 -> alu_a=0x1234, alu_b=0x0001; tx 35 then 12; busy drops after the second strobe; err_flag=0.
- Chaining, following the previous frame: bytes 81,02,00 -> alu_b=0x1235 without receiving B; tx 37,12.
- Backpressure: hold tx_busy=1 for 20 cycles after the first strobe -> second tx_en appears only on the first cycle tx_busy=0; txd is stable during the strobe.
- Timeout: TIMEOUT=100; send 01,34 then idle -> after 100 cycles a single tx EE, err_flag=1. Next valid opcode clears err_flag.
- rx_error coincident with the third byte of a frame -> byte discarded, tx EE, result register unchanged; a following CHAIN frame uses the old result.
- Assert rst for 1 cycle between the two strobes of a TX -> no second strobe; all outputs 0 next cycle. A fresh frame then works normally; CHAIN uses B=0.

Source files
------------

// File: rtl/mpu_cmd_ctrl.sv
// mpu_cmd_ctrl: assembles multi-byte ALU commands from the UART receive stream,
// waits out the ALU latency and serialises the result back to the UART transmitter.
module mpu_cmd_ctrl #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned FUNC_W   = 4,
    parameter int unsigned ALU_LAT  = 1,
    parameter int unsigned TIMEOUT  = 50000,
    parameter logic [7:0]  ERR_BYTE = 8'hEE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_complete,
    input  logic              rx_error,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [FUNC_W-1:0] alu_func,
    output logic [7:0]        txd,
    output logic              tx_en,
    input  logic              tx_busy,
    output logic              busy,
    output logic              err_flag
);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned IDX_W = $clog2(NB + 1);
    localparam int unsigned LAT_W = $clog2(ALU_LAT + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RX_A = 3'd1;
    localparam logic [2:0] S_RX_B = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_TX   = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    logic [2:0]        state, state_d;
    logic [IDX_W-1:0]  idx, idx_d;
    logic [LAT_W-1:0]  lat_cnt, lat_cnt_d;
    logic [TO_W-1:0]   to_cnt, to_cnt_d;
    logic              chain, chain_d;
    logic [DATA_W-1:0] result, result_d;
    logic [DATA_W-1:0] alu_a_d, alu_b_d;
    logic [FUNC_W-1:0] alu_func_d;
    logic [7:0]        txd_d;
    logic              tx_en_d, busy_d, err_flag_d;
    logic              strobe_ok;

    // A strobe needs an idle transmitter and a one-cycle gap after the previous strobe.
    assign strobe_ok = !tx_busy && !tx_en;

    always_comb begin
        state_d    = state;
        idx_d      = idx;
        lat_cnt_d  = lat_cnt;
        to_cnt_d   = to_cnt;
        chain_d    = chain;
        result_d   = result;
        alu_a_d    = alu_a;
        alu_b_d    = alu_b;
        alu_func_d = alu_func;
        txd_d      = txd;
        tx_en_d    = 1'b0;
        err_flag_d = err_flag;

        case (state)
            S_IDLE: begin
                if (rx_error) begin
                    err_flag_d = 1'b1;
                end else if (rx_complete) begin
                    alu_func_d = rx_data[FUNC_W-1:0];
                    chain_d    = rx_data[7];
                    err_flag_d = 1'b0;
                    idx_d      = '0;
                    to_cnt_d   = '0;
                    state_d    = S_RX_A;
                end
            end

            S_RX_A, S_RX_B: begin
                if (rx_error) begin
                    state_d = S_ERR;
                end else if (rx_complete) begin
                    to_cnt_d = '0;
                    for (int i = 0; i < NB; i++) begin
                        if (idx == IDX_W'(i)) begin
                            if (state == S_RX_A) alu_a_d[i*8 +: 8] = rx_data;
                            else                 alu_b_d[i*8 +: 8] = rx_data;
                        end
                    end
                    if (idx == IDX_W'(NB - 1)) begin
                        idx_d = '0;
                        if (state == S_RX_A && !chain) begin
                            state_d = S_RX_B;
                        end else begin
                            if (state == S_RX_A) alu_b_d = result;
                            lat_cnt_d = '0;
                            state_d   = S_EXEC;
                        end
                    end else begin
                        idx_d = idx + IDX_W'(1);
                    end
                end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end else begin
                    to_cnt_d = to_cnt + TO_W'(1);
                end
            end

            // Operands have been stable since entry; sample once the ALU latency has elapsed.
            S_EXEC: begin
                if (lat_cnt == LAT_W'(ALU_LAT)) begin
                    result_d = alu_result;
                    idx_d    = '0;
                    state_d  = S_TX;
                end else begin
                    lat_cnt_d = lat_cnt + LAT_W'(1);
                end
            end

            S_TX: begin
                if (strobe_ok) begin
                    tx_en_d = 1'b1;
                    for (int i = 0; i < NB; i++) begin
                        if (idx == IDX_W'(i)) txd_d = result[i*8 +: 8];
                    end
                    if (idx == IDX_W'(NB - 1)) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx + IDX_W'(1);
                    end
                end
            end

            S_ERR: begin
                if (strobe_ok) begin
                    tx_en_d    = 1'b1;
                    txd_d      = ERR_BYTE;
                    err_flag_d = 1'b1;
                    state_d    = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            idx      <= '0;
            lat_cnt  <= '0;
            to_cnt   <= '0;
            chain    <= 1'b0;
            result   <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_func <= '0;
            txd      <= '0;
            tx_en    <= 1'b0;
            busy     <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            state    <= state_d;
            idx      <= idx_d;
            lat_cnt  <= lat_cnt_d;
            to_cnt   <= to_cnt_d;
            chain    <= chain_d;
            result   <= result_d;
            alu_a    <= alu_a_d;
            alu_b    <= alu_b_d;
            alu_func <= alu_func_d;
            txd      <= txd_d;
            tx_en    <= tx_en_d;
            busy     <= busy_d;
            err_flag <= err_flag_d;
        end
    end
endmodule

// File: tb/tb_mpu_cmd_ctrl.sv
// Self-checking bench for mpu_cmd_ctrl: frame-level reference model, pipelined ALU
// and a transmitter model with randomised busy hold times.
module tb_mpu_cmd_ctrl;
    localparam int DATA_W  = 16;
    localparam int FUNC_W  = 4;
    localparam int ALU_LAT = 2;
    localparam int TIMEOUT = 100;
    localparam int NB      = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_complete, rx_error, tx_busy;
    logic [DATA_W-1:0] alu_result, alu_a, alu_b;
    logic [FUNC_W-1:0] alu_func;
    logic [7:0]        txd;
    logic              tx_en, busy, err_flag;

    mpu_cmd_ctrl #(.DATA_W(DATA_W), .FUNC_W(FUNC_W), .ALU_LAT(ALU_LAT),
                   .TIMEOUT(TIMEOUT), .ERR_BYTE(8'hEE)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_complete(rx_complete),
        .rx_error(rx_error), .alu_result(alu_result), .alu_a(alu_a), .alu_b(alu_b),
        .alu_func(alu_func), .txd(txd), .tx_en(tx_en), .tx_busy(tx_busy),
        .busy(busy), .err_flag(err_flag));

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] alu_f(input logic [3:0] f, input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        case (f)
            4'h1:    return a + b;
            4'h2:    return a - b;
            4'h3:    return a ^ b;
            default: return a & b;
        endcase
    endfunction

    // External ALU: two-stage pipeline, matching ALU_LAT = 2.
    logic [DATA_W-1:0] alu_p1;
    always @(posedge clk) begin
        alu_p1     <= alu_f(alu_func, alu_a, alu_b);
        alu_result <= alu_p1;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int         cyc;
        logic [7:0] b;
        int         hold;
        logic       busy;
        logic       errf;
    } strobe_t;

    strobe_t sq[$];
    int cyc = 0;
    int force_hold = -1;
    int busy_cnt = 0;
    int viol = 0;

    // Transmitter model: records every strobe and holds tx_busy for a random time after it.
    initial begin
        logic pre;
        int   h;
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            pre = tx_busy;
            #1;
            if (tx_en === 1'b1) begin
                if (pre) viol++;
                h = (force_hold >= 0) ? force_hold : int'($urandom_range(0, 3));
                force_hold = -1;
                sq.push_back('{cyc: cyc, b: txd, hold: h, busy: busy, errf: err_flag});
                busy_cnt = h;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            tx_busy = (busy_cnt > 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    logic [DATA_W-1:0] model_res = '0;
    logic              model_err = 1'b0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic err, input int gap, output int t);
        repeat (gap) @(posedge clk);
        @(posedge clk); #1;
        rx_data = b; rx_complete = 1'b1; rx_error = err;
        @(posedge clk); #1;
        t = cyc;
        rx_complete = 1'b0; rx_error = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int budget, input string tag);
        int k = 0;
        while (sq.size() < n && k < budget) begin
            @(posedge clk); #2;
            k++;
        end
        check(tag, sq.size(), n);
    endtask

    // One command frame; err_idx >= 1 injects rx_error on that byte, stray drops a byte during EXEC.
    task automatic do_frame(input logic [7:0] op, input logic [DATA_W-1:0] a,
                            input logic [DATA_W-1:0] b, input int err_idx, input logic stray);
        logic [7:0]        fr[$];
        logic [DATA_W-1:0] b_eff, r;
        int t, t2, eg;
        for (int i = 0; i < NB; i++) fr.push_back(a[i*8 +: 8]);
        if (!op[7]) for (int i = 0; i < NB; i++) fr.push_back(b[i*8 +: 8]);
        fr.push_front(op);
        b_eff = op[7] ? model_res : b;
        sq.delete();
        for (int i = 0; i < fr.size(); i++) begin
            if (i == err_idx) begin
                send_byte(fr[i], 1'b1, int'($urandom_range(0, 2)), t);
                break;
            end
            send_byte(fr[i], 1'b0, int'($urandom_range(0, 2)), t);
        end
        if (err_idx >= 1 && err_idx < fr.size()) begin
            wait_strobes(1, 50, "err_strobe_cnt");
            if (sq.size() < 1) return;
            check("err_byte", sq[0].b, 8'hEE);
            check("err_latency", sq[0].cyc - t, 1);
            check("err_flag_at_strobe", sq[0].errf, 1'b1);
            model_err = 1'b1;
            tick(8);
            check("err_single", sq.size(), 1);
        end else begin
            check("alu_a", alu_a, a);
            check("alu_b", alu_b, b_eff);
            check("alu_func", alu_func, op[3:0]);
            if (stray) send_byte(8'($urandom), 1'b0, 0, t2);
            r = alu_f(op[3:0], a, b_eff);
            model_res = r;
            model_err = 1'b0;
            wait_strobes(NB, 200, "tx_strobe_cnt");
            if (sq.size() < NB) return;
            for (int j = 0; j < NB; j++) begin
                check("tx_byte", sq[j].b, r[j*8 +: 8]);
                check("busy_at_strobe", sq[j].busy, (j != NB - 1));
                check("errf_at_strobe", sq[j].errf, 1'b0);
                if (j == 0) begin
                    check("first_tx_latency", sq[0].cyc - t, 2 + ALU_LAT);
                end else begin
                    eg = (sq[j-1].hold + 1 > 2) ? sq[j-1].hold + 1 : 2;
                    check("tx_gap", sq[j].cyc - sq[j-1].cyc, eg);
                end
            end
            tick(6);
            check("tx_no_extra", sq.size(), NB);
        end
        check("end_busy", busy, 1'b0);
        check("end_err_flag", err_flag, model_err);
    endtask

    initial begin
        int t;
        logic [7:0] op;
        int kind, flen;
        rst = 1'b1; rx_data = '0; rx_complete = 1'b0; rx_error = 1'b0;
        tick(3);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_outs", {alu_func, txd, tx_en, busy, err_flag}, 0);
        rst = 1'b0;
        tick(2);

        // Add, then chain onto the previous result.
        do_frame(8'h01, 16'h1234, 16'h0001, -1, 1'b0);
        do_frame(8'h81, 16'h0002, 16'h0000, -1, 1'b0);

        // Long backpressure after the first strobe.
        force_hold = 20;
        do_frame(8'h03, 16'hA5C3, 16'h0FF0, -1, 1'b0);

        // Inter-byte timeout after opcode and one A byte.
        sq.delete();
        send_byte(8'h01, 1'b0, 0, t);
        send_byte(8'h34, 1'b0, 0, t);
        wait_strobes(1, TIMEOUT + 20, "timeout_strobe_cnt");
        if (sq.size() >= 1) begin
            check("timeout_byte", sq[0].b, 8'hEE);
            check("timeout_window", (sq[0].cyc - t >= TIMEOUT) && (sq[0].cyc - t <= TIMEOUT + 2), 1'b1);
        end
        tick(20);
        check("timeout_single", sq.size(), 1);
        check("timeout_err_flag", err_flag, 1'b1);
        check("timeout_busy", busy, 1'b0);
        model_err = 1'b1;
        do_frame(8'h02, 16'h0100, 16'h0001, -1, 1'b0);

        // rx_error on the third byte, then chain on the unchanged result.
        do_frame(8'h01, 16'h4444, 16'h1111, 2, 1'b0);
        do_frame(8'h81, 16'h0001, 16'h0000, -1, 1'b0);

        // rx_error while idle only flags.
        sq.delete();
        send_byte(8'h55, 1'b1, 0, t);
        tick(10);
        check("idle_err_flag", err_flag, 1'b1);
        check("idle_err_busy", busy, 1'b0);
        check("idle_err_no_tx", sq.size(), 0);
        model_err = 1'b1;
        do_frame(8'h01, 16'h0010, 16'h0020, -1, 1'b1);

        // Reset between the two strobes of a transmit.
        sq.delete();
        force_hold = 10;
        send_byte(8'h01, 1'b0, 0, t);
        send_byte(8'h11, 1'b0, 0, t);
        send_byte(8'h22, 1'b0, 0, t);
        send_byte(8'h33, 1'b0, 0, t);
        send_byte(8'h44, 1'b0, 0, t);
        wait_strobes(1, 50, "rst_first_strobe");
        tick(3);
        rst = 1'b1;
        tick(1);
        check("midtx_rst_alu", {alu_a, alu_b}, 0);
        check("midtx_rst_outs", {alu_func, txd, tx_en, busy, err_flag}, 0);
        rst = 1'b0;
        tick(30);
        check("midtx_no_second", sq.size(), 1);
        model_res = '0;
        model_err = 1'b0;
        do_frame(8'h81, 16'h7777, 16'h0000, -1, 1'b0);

        // Randomised frames.
        for (int n = 0; n < 40; n++) begin
            kind = int'($urandom_range(0, 9));
            op = 8'($urandom);
            op[7] = (kind >= 6 && kind <= 7);
            flen = op[7] ? 1 + NB : 1 + 2 * NB;
            do_frame(op, 16'($urandom), 16'($urandom),
                     (kind >= 8) ? int'($urandom_range(1, flen - 1)) : -1,
                     1'($urandom));
        end

        check("no_strobe_while_busy", viol, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
